// File: rtl/muxarb.sv
// Round-robin arbiter sharing one registered DW-bit output channel between N requesters.
// Optional grant locking is compiled in with `define MUXARB_LOCK_EN (adds the req_lock port).
module muxarb #(
    parameter  int DW = 32,
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
`ifdef MUXARB_LOCK_EN
    input  logic [N-1:0]    req_lock,
`endif
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [IW-1:0]   out_id,
    input  logic            out_ready
);

    // Handshake: a beat moves when valid and ready are both high at a rising
    // clk edge. req_ready is offered combinationally to the single winner only,
    // whenever the output register is empty or is being drained this cycle.
    localparam logic [N-1:0] ONE = N'(1);

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [N-1:0]  elig;
    logic          found;
    logic          accept;
    logic          hs;

`ifdef MUXARB_LOCK_EN
    logic          lock_act;
    logic [IW-1:0] lock_id;

    always_comb begin
        elig = lock_act ? (req_valid & (ONE << lock_id)) : req_valid;
    end
`else
    always_comb begin
        elig = req_valid;
    end
`endif

    // Scan from ptr upwards with wraparound; N need not be a power of two.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && elig[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = IW'((int'(ptr) + k) % N);
            end
        end
    end

    assign accept    = ~out_valid | out_ready;
    assign hs        = accept & found;
    assign req_ready = hs ? (ONE << win) : '0;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (hs) begin
            out_valid <= 1'b1;
            out_data  <= req_data[int'(win)*DW +: DW];
            out_id    <= win;
            ptr       <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUXARB_LOCK_EN
    // While locked only lock_id is eligible, so win == lock_id on every locked beat.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lock_act <= 1'b0;
            lock_id  <= '0;
        end else if (hs) begin
            lock_act <= req_lock[win];
            if (req_lock[win]) begin
                lock_id <= win;
            end
        end
    end
`endif

endmodule

// File: tb/tb_muxarb.sv
// Directed bench for muxarb (N=4, DW=32); the locked-grant sequence runs when MUXARB_LOCK_EN is defined.
module tb_muxarb;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W  = IW + DW;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            out_ready;
    logic [N-1:0]    lock_next;
`ifdef MUXARB_LOCK_EN
    logic [N-1:0]    req_lock;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    muxarb #(.DW(DW), .N(N)) dut (
`ifdef MUXARB_LOCK_EN
        .req_lock (req_lock),
`endif
        .clk      (clk),
        .nreset   (nreset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_id   (out_id),
        .out_ready(out_ready)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge; return at the falling edge.
    task automatic drive(input logic [N-1:0] valid, input logic rdy, input logic [DW-1:0] base);
        @(posedge clk);
        #1;
        req_valid = valid;
        out_ready = rdy;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base + DW'(i);
`ifdef MUXARB_LOCK_EN
        req_lock = lock_next;
`endif
        @(negedge clk);
    endtask

    task automatic grant(input int lane, input logic [DW-1:0] base);
        exp_q.push_back({IW'(lane), base + DW'(lane)});
    endtask

    task automatic check_out(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_id"}, 32'(out_id), 32'(e[W-1:DW]));
            check({tag, "_data"}, out_data, e[DW-1:0]);
        end
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_id"}, 32'(out_id), 32'(exp_q[0][W-1:DW]));
        check({tag, "_data"}, out_data, exp_q[0][DW-1:0]);
    endtask

    initial begin
        nreset    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        lock_next = '0;
`ifdef MUXARB_LOCK_EN
        req_lock  = '0;
`endif
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        @(posedge clk);
        #1 nreset = 1'b1;

        // idle: nothing requested
        repeat (10) begin
            drive(4'b0000, 1'b1, 32'h0);
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_ready", 32'(req_ready), 32'd0);
        end

        // all lanes requesting: 0,1,2,3,0,1,2,3
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, 1'b1, DW'(c * 256));
            check("rr_ready", 32'(req_ready), 32'd1 << (c % 4));
            if (c > 0) check_out("rr");
            grant(c % 4, DW'(c * 256));
        end
        drive(4'b0000, 1'b1, 32'h0);
        check("rr_end_ready", 32'(req_ready), 32'd0);
        check_out("rr_last");
        drive(4'b0000, 1'b1, 32'h0);
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_id", 32'(out_id), 32'd3);
        check("drain_data", out_data, 32'h703);

        // move ptr to 2, then 1010 -> lane 3 then lane 1
        drive(4'b0010, 1'b1, 32'h1000);
        check("p2_ready", 32'(req_ready), 32'b0010);
        grant(1, 32'h1000);
        drive(4'b1010, 1'b1, 32'h2000);
        check("w3_ready", 32'(req_ready), 32'b1000);
        check_out("p2");
        grant(3, 32'h2000);
        drive(4'b1010, 1'b1, 32'h3000);
        check("w1_ready", 32'(req_ready), 32'b0010);
        check_out("w3");
        grant(1, 32'h3000);

        // back-pressure: output holds, nobody is granted
        for (int c = 0; c < 3; c++) begin
            drive(4'b1010, 1'b0, 32'h4000);
            check("bp_ready", 32'(req_ready), 32'd0);
            check_hold("bp");
        end

        // release: drain and refill in the same cycle
        drive(4'b0100, 1'b1, 32'h5000);
        check("rel_ready", 32'(req_ready), 32'b0100);
        check_out("w1");
        grant(2, 32'h5000);
        drive(4'b0000, 1'b1, 32'h0);
        check_out("rel");

        // reset while a beat is buffered; ptr (3 -> 1 after this grant) must return to 0
        drive(4'b0001, 1'b1, 32'h6000);
        check("pre_rst_ready", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        out_ready = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        nreset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_id", 32'(out_id), 32'd0);
        @(posedge clk);
        #1 nreset = 1'b1;
        drive(4'b1111, 1'b1, 32'h7000);
        check("post_rst_ready", 32'(req_ready), 32'b0001);
        grant(0, 32'h7000);
        drive(4'b0000, 1'b1, 32'h0);
        check_out("post_rst");

`ifdef MUXARB_LOCK_EN
        // ptr=1: lane 1 locks for three beats, then 2, 0 round-robin
        lock_next = 4'b0010;
        drive(4'b0111, 1'b1, 32'h8000);
        check("lk1_ready", 32'(req_ready), 32'b0010);
        grant(1, 32'h8000);
        drive(4'b0101, 1'b1, 32'h9000);
        check("lk_idle_ready", 32'(req_ready), 32'd0);
        check_out("lk1");
        drive(4'b0111, 1'b1, 32'hA000);
        check("lk2_ready", 32'(req_ready), 32'b0010);
        check("lk_idle_valid", 32'(out_valid), 32'd0);
        grant(1, 32'hA000);
        lock_next = 4'b0000;
        drive(4'b0111, 1'b1, 32'hB000);
        check("lk3_ready", 32'(req_ready), 32'b0010);
        check_out("lk2");
        grant(1, 32'hB000);
        drive(4'b0101, 1'b1, 32'hC000);
        check("ul2_ready", 32'(req_ready), 32'b0100);
        check_out("lk3");
        grant(2, 32'hC000);
        drive(4'b0001, 1'b1, 32'hD000);
        check("ul0_ready", 32'(req_ready), 32'b0001);
        check_out("ul2");
        grant(0, 32'hD000);
        drive(4'b0000, 1'b1, 32'h0);
        check_out("ul0");
`endif

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
